// File: rtl/instr_fetch_if.sv
// Instruction-memory bus between the fetch stage and the instruction memory.
// Single-beat request/acknowledge: the master holds imem_req/imem_addr until
// imem_ack, which may arrive in the same cycle as the request or later.
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage with IF/ID register, one-entry skid buffer for
// decode stalls, and a drop state that swallows the response of a request
// that was already outstanding when a redirect arrived.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall_d,
    input  logic                 redirect,
    input  logic [31:0]          redirect_pc,
    instr_fetch_if.master        imem,
    output logic [31:0]          instr_d,
    output logic [31:0]          pc_plus4_d,
    output logic                 valid_d,
    output logic [5:0]           op_d,
    output logic [5:0]           funct_d
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,   // request outstanding at addr_q
        S_HOLD  = 2'd1,   // response parked in skid buffer, decode stalled
        S_DROP  = 2'd2    // old request still in flight, its data is discarded
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;          // address currently presented to memory
    logic [31:0] pc_q, pc_d;              // fetch address to resume from after a drop
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc4_q, skid_pc4_d;
    logic        skid_valid_q, skid_valid_d;

    logic [31:0] target;
    logic [31:0] addr_inc;

    // Redirect targets are forced word aligned; all address math wraps mod 2^32.
    assign target   = redirect_pc & 32'hFFFF_FFFC;
    assign addr_inc = addr_q + 32'd4;

    // Next-state and datapath update for the fetch controller.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;
        skid_valid_d = skid_valid_q;

        // A redirect always flushes IF/ID and the skid buffer, even when stalled.
        if (redirect) begin
            ifid_instr_d = 32'h0000_0000;
            ifid_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end

        case (state_q)
            S_FETCH: begin
                if (redirect) begin
                    if (imem.imem_ack) begin
                        // Response completes this cycle: drop it and restart at target.
                        addr_d = target;
                    end else begin
                        // Request still pending: keep address stable until it completes.
                        pc_d    = target;
                        state_d = S_DROP;
                    end
                end else if (imem.imem_ack) begin
                    addr_d = addr_inc;
                    pc_d   = addr_inc;
                    if (stall_d) begin
                        skid_instr_d = imem.imem_rdata;
                        skid_pc4_d   = addr_inc;
                        skid_valid_d = 1'b1;
                        state_d      = S_HOLD;
                    end else begin
                        ifid_instr_d = imem.imem_rdata;
                        ifid_pc4_d   = addr_inc;
                        ifid_valid_d = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    addr_d  = target;
                    pc_d    = target;
                    state_d = S_FETCH;
                end else if (!stall_d) begin
                    ifid_instr_d = skid_instr_q;
                    ifid_pc4_d   = skid_pc4_q;
                    ifid_valid_d = skid_valid_q;
                    skid_valid_d = 1'b0;
                    state_d      = S_FETCH;
                end
            end
            S_DROP: begin
                if (redirect) begin
                    pc_d = target;
                end
                if (imem.imem_ack) begin
                    // A redirect landing together with the ack still wins.
                    addr_d  = redirect ? target : pc_q;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_FETCH;
            addr_q       <= RESET_PC;
            pc_q         <= RESET_PC;
            ifid_instr_q <= 32'h0000_0000;
            ifid_pc4_q   <= 32'h0000_0000;
            ifid_valid_q <= 1'b0;
            skid_instr_q <= 32'h0000_0000;
            skid_pc4_q   <= 32'h0000_0000;
            skid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    // No request while in reset or while a response is parked.
    assign imem.imem_req  = !reset && (state_q != S_HOLD);
    assign imem.imem_addr = addr_q;

    assign instr_d    = ifid_instr_q;
    assign pc_plus4_d = ifid_pc4_q;
    assign valid_d    = ifid_valid_q;
    assign op_d       = ifid_instr_q[31:26];
    assign funct_d    = ifid_instr_q[5:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch. Memory word at address a is a ^ 32'h5A5A_0000;
// ack arrives after 'lat' cycles of an outstanding request (0 = same cycle).
module tb_instr_fetch;

    logic        clk;
    logic        reset;
    logic        stall_d;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;
    logic [5:0]  op_d;
    logic [5:0]  funct_d;

    int          n_checks;
    int          n_errors;
    int          lat;
    int          wait_cnt;

    instr_fetch_if imem_bus ();

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall_d     (stall_d),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (imem_bus.master),
        .instr_d     (instr_d),
        .pc_plus4_d  (pc_plus4_d),
        .valid_d     (valid_d),
        .op_d        (op_d),
        .funct_d     (funct_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: counts cycles a request has been waiting.
    always_ff @(posedge clk) begin
        if (reset || imem_bus.imem_ack || !imem_bus.imem_req)
            wait_cnt <= 0;
        else
            wait_cnt <= wait_cnt + 1;
    end

    assign imem_bus.imem_ack   = imem_bus.imem_req && (wait_cnt >= lat);
    assign imem_bus.imem_rdata = imem_bus.imem_addr ^ 32'h5A5A_0000;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end else begin
            $display("ok   %s: %08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        lat         = 0;
        reset       = 1'b1;
        stall_d     = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;

        // Reset state
        tick();
        tick();
        chk("rst_req",   {31'b0, imem_bus.imem_req}, 32'h0);
        chk("rst_valid", {31'b0, valid_d}, 32'h0);
        chk("rst_instr", instr_d, 32'h0);
        chk("rst_pc4",   pc_plus4_d, 32'h0);
        reset = 1'b0;
        #1;
        chk("post_rst_req",  {31'b0, imem_bus.imem_req}, 32'h1);
        chk("post_rst_addr", imem_bus.imem_addr, 32'h0);

        // Back-to-back fetch A,B,C with same-cycle ack
        tick();
        chk("seq_A_instr", instr_d, 32'h5A5A_0000);
        chk("seq_A_pc4",   pc_plus4_d, 32'h4);
        chk("seq_A_valid", {31'b0, valid_d}, 32'h1);
        tick();
        chk("seq_B_instr", instr_d, 32'h5A5A_0004);
        chk("seq_B_pc4",   pc_plus4_d, 32'h8);
        chk("seq_B_op",    {26'b0, op_d}, 32'h16);
        chk("seq_B_funct", {26'b0, funct_d}, 32'h04);
        tick();
        chk("seq_C_instr", instr_d, 32'h5A5A_0008);
        chk("seq_C_pc4",   pc_plus4_d, 32'hC);

        // Restart, then stall for 3 cycles while B returns
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("st_A_instr", instr_d, 32'h5A5A_0000);
        stall_d = 1'b1;
        tick();
        chk("st1_instr", instr_d, 32'h5A5A_0000);
        chk("st1_valid", {31'b0, valid_d}, 32'h1);
        chk("st1_req",   {31'b0, imem_bus.imem_req}, 32'h0);
        tick();
        chk("st2_instr", instr_d, 32'h5A5A_0000);
        chk("st2_req",   {31'b0, imem_bus.imem_req}, 32'h0);
        tick();
        chk("st3_instr", instr_d, 32'h5A5A_0000);
        chk("st3_pc4",   pc_plus4_d, 32'h4);
        stall_d = 1'b0;
        tick();
        chk("rel_B_instr", instr_d, 32'h5A5A_0004);
        chk("rel_B_pc4",   pc_plus4_d, 32'h8);
        chk("rel_addr",    imem_bus.imem_addr, 32'h8);
        tick();
        chk("rel_C_instr", instr_d, 32'h5A5A_0008);
        chk("rel_C_pc4",   pc_plus4_d, 32'hC);

        // Redirect to 0x103 while a 2-cycle-late request is pending
        lat         = 2;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        tick();
        redirect = 1'b0;
        chk("drop_valid",  {31'b0, valid_d}, 32'h0);
        chk("drop_instr",  instr_d, 32'h0);
        chk("drop_addr1",  imem_bus.imem_addr, 32'hC);
        tick();
        chk("drop_addr2",  imem_bus.imem_addr, 32'hC);
        chk("drop_ack",    {31'b0, imem_bus.imem_ack}, 32'h1);
        tick();
        chk("drop_valid2", {31'b0, valid_d}, 32'h0);
        chk("drop_newaddr", imem_bus.imem_addr, 32'h100);
        lat = 0;
        tick();
        chk("tgt_instr", instr_d, 32'h5A5A_0100);
        chk("tgt_pc4",   pc_plus4_d, 32'h104);

        // Redirect together with stall while a word is parked
        stall_d = 1'b1;
        tick();
        chk("hold_instr", instr_d, 32'h5A5A_0100);
        chk("hold_req",   {31'b0, imem_bus.imem_req}, 32'h0);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        redirect = 1'b0;
        stall_d  = 1'b0;
        chk("hr_valid", {31'b0, valid_d}, 32'h0);
        chk("hr_instr", instr_d, 32'h0);
        chk("hr_addr",  imem_bus.imem_addr, 32'h200);
        tick();
        chk("hr_tgt_instr", instr_d, 32'h5A5A_0200);
        chk("hr_tgt_pc4",   pc_plus4_d, 32'h204);

        // Redirect to top of address space with same-cycle ack, then wrap
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        chk("wrap_valid", {31'b0, valid_d}, 32'h0);
        chk("wrap_addr",  imem_bus.imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_instr", instr_d, 32'hA5A5_FFFC);
        chk("wrap_pc4",   pc_plus4_d, 32'h0);
        chk("wrap_next",  imem_bus.imem_addr, 32'h0);
        tick();
        chk("wrap_0_instr", instr_d, 32'h5A5A_0000);
        chk("wrap_0_pc4",   pc_plus4_d, 32'h4);

        // Redirect in DROP overwrites the resume address
        lat         = 3;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0300;
        tick();
        redirect_pc = 32'h0000_0400;
        tick();
        redirect = 1'b0;
        chk("dd_addr_hold", imem_bus.imem_addr, 32'h4);
        tick();
        chk("dd_ack", {31'b0, imem_bus.imem_ack}, 32'h1);
        tick();
        chk("dd_addr_new", imem_bus.imem_addr, 32'h400);
        chk("dd_valid",    {31'b0, valid_d}, 32'h0);

        // Reset pulse while in DROP
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0500;
        tick();
        redirect = 1'b0;
        reset    = 1'b1;
        #1;
        chk("rd_req_in_rst", {31'b0, imem_bus.imem_req}, 32'h0);
        tick();
        chk("rd_req_rst2", {31'b0, imem_bus.imem_req}, 32'h0);
        chk("rd_valid",    {31'b0, valid_d}, 32'h0);
        chk("rd_instr",    instr_d, 32'h0);
        reset = 1'b0;
        lat   = 0;
        #1;
        chk("rd_post_req",  {31'b0, imem_bus.imem_req}, 32'h1);
        chk("rd_post_addr", imem_bus.imem_addr, 32'h0);
        tick();
        chk("rd_first_instr", instr_d, 32'h5A5A_0000);
        chk("rd_first_pc4",   pc_plus4_d, 32'h4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: stall_d  input  1  decode stage cannot accept; hold IF/ID outputs.
REQ-005 Port: redirect  input  1  taken branch or jump from control path; flush and refetch.
REQ-006 Port: redirect_pc  input  32  target address; bits [1:0] forced to 2'b00 internally.
REQ-007 Port: imem_req  output  1  instruction memory request.
REQ-008 Port: imem_addr  output  32  word-aligned fetch address.
REQ-009 Port: imem_ack  input  1  single-beat response; may assert in the same cycle as imem_req or later.
REQ-010 Port: imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-011 Port: instr_d  output  32  IF/ID instruction register.
REQ-012 Port: pc_plus4_d  output  32  fetch address + 4 of instr_d.
REQ-013 Port: valid_d  output  1  instr_d holds a live instruction.
REQ-014 Port: op_d  output  6  instr_d[31:26], combinational.
REQ-015 Port: funct_d  output  6  instr_d[5:0], combinational.

Function
REQ-016 The FSM SHALL have three states: FETCH (request outstanding), HOLD (response buffered, decode stalled), DROP (discard in-flight response after redirect).
REQ-017 The block SHALL keep fetch address register addr_q driving imem_addr and next-PC register pc_q; imem_addr SHALL stay stable while imem_req=1 and imem_ack=0.
REQ-018 imem_req SHALL be 1 in FETCH and DROP and 0 in HOLD.
REQ-019 FETCH, imem_ack=1, stall_d=0, redirect=0: instr_d<=imem_rdata, pc_plus4_d<=addr_q+4, valid_d<=1, addr_q<=addr_q+4, remain in FETCH; throughput one instruction per cycle when ack is same-cycle.
REQ-020 FETCH, imem_ack=1, stall_d=1: imem_rdata and addr_q+4 SHALL be captured in a one-entry skid buffer, addr_q<=addr_q+4, go to HOLD; instr_d/valid_d unchanged.
REQ-021 HOLD, stall_d=0: skid buffer SHALL move to instr_d/pc_plus4_d with valid_d<=1, go to FETCH.
REQ-022 While stall_d=1 and redirect=0, instr_d, pc_plus4_d and valid_d SHALL hold.
REQ-023 redirect=1 SHALL override stall_d: next cycle valid_d=0, instr_d=32'h0000_0000 (NOP), skid buffer invalidated.
REQ-024 redirect in FETCH with imem_ack=1, or in HOLD: addr_q<={redirect_pc[31:2],2'b00}, go to FETCH; any same-cycle response SHALL be discarded.
REQ-025 redirect in FETCH with imem_ack=0: pc_q<={redirect_pc[31:2],2'b00}, go to DROP, addr_q unchanged.
REQ-026 DROP: on imem_ack=1 the data SHALL be discarded, addr_q<=pc_q, go to FETCH; a further redirect in DROP SHALL overwrite pc_q only.
REQ-027 Address arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC+4 = 32'h0000_0000.
REQ-028 Instructions SHALL be delivered in program order with no duplication or loss except those flushed by redirect.

Reset
REQ-029 reset=1 SHALL win over all other inputs and give: state FETCH, addr_q=pc_q=RESET_PC, valid_d=0, instr_d=0, pc_plus4_d=0, skid buffer empty.
REQ-030 imem_req SHALL be 0 while reset=1 and 1 (address RESET_PC) in the first cycle after reset deasserts.
REQ-031 Reset asserted with a request outstanding SHALL abandon it; the memory model is reset together with this block.

Verification
REQ-032 Same-cycle ack, words A,B,C from 0x0: instr_d=A,B,C on consecutive cycles, pc_plus4_d=4,8,C, valid_d=1.
REQ-033 stall_d=1 for 3 cycles while ack returns B: instr_d stays A, imem_req=0 in HOLD; after release instr_d=B, then C fetched from 0x8.
REQ-034 redirect=1, redirect_pc=0x0000_0103 with ack 2 cycles late: late data dropped, valid_d=0, next imem_addr=0x0000_0100.
REQ-035 redirect and stall_d both 1 in HOLD: valid_d=0 next cycle, buffered word never appears, fetch from target.
REQ-036 redirect_pc=0xFFFF_FFFC, same-cycle ack: pc_plus4_d=0x0000_0000, next imem_addr=0x0000_0000.
REQ-037 reset pulsed mid-DROP: imem_req=0 during reset, valid_d=0, first post-reset imem_addr=RESET_PC.
